arbitro_vc_d: RTL

Virtual-channel arbiter between the two VC FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the arqui datapath. Each cycle it picks at most one head word from VC0 or VC1, pops it, and forwards it one cycle later to the D FIFO named by the word's destination bit. It honours D FIFO pause (almost-full) per destination without head-of-line blocking across VCs. A bounded-burst rule keeps VC1 from starving behind VC0.

---
 rtl/arbitro_vc_d.sv | 93 +++++++++
 1 files changed

// File: rtl/arbitro_vc_d.sv
// Virtual-channel arbiter: pops at most one head word per cycle from VC0/VC1 and
// forwards it, one cycle later, to the D FIFO selected by the word's destination bit.
module arbitro_vc_d #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4,
  parameter int BURST     = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic                 vc0_empty,
  output logic                 vc0_pop,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 vc1_empty,
  output logic                 vc1_pop,
  input  logic                 d0_pause,
  input  logic                 d1_pause,
  output logic [DATA_SIZE-1:0] d_data,
  output logic                 d0_push,
  output logic                 d1_push,
  output logic [7:0]           sent0,
  output logic [7:0]           sent1,
  output logic                 idle_arb
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= BURST_MAX) ? BURST_MAX : v + 1'b1;
  endfunction

  logic                 elig0_p0;
  logic                 elig1_p0;
  logic                 grant0_p0;
  logic                 grant1_p0;
  logic                 vld_p0;
  logic [DATA_SIZE-1:0] word_p0;
  logic [CNT_W-1:0]     burst_cnt;
  logic [CNT_W-1:0]     burst_cnt_nxt;

  // Stage p0: eligibility, grant and pop, all in the current cycle
  always_comb begin
    elig0_p0  = reset_L & enable & ~vc0_empty &
                ~(vc0_data[DEST_BIT] ? d1_pause : d0_pause);
    elig1_p0  = reset_L & enable & ~vc1_empty &
                ~(vc1_data[DEST_BIT] ? d1_pause : d0_pause);
    // VC1 wins once VC0 has used up its burst, or whenever VC0 cannot go
    grant1_p0 = elig1_p0 & ((burst_cnt == BURST_MAX) | ~elig0_p0);
    grant0_p0 = elig0_p0 & ~grant1_p0;
    vld_p0    = grant0_p0 | grant1_p0;
    word_p0   = grant1_p0 ? vc1_data : vc0_data;

    burst_cnt_nxt = burst_cnt;
    if (grant1_p0 || !elig1_p0) begin
      burst_cnt_nxt = '0;
    end else if (grant0_p0) begin
      burst_cnt_nxt = sat_inc(burst_cnt);
    end
  end

  assign vc0_pop = grant0_p0;
  assign vc1_pop = grant1_p0;

  // Stage p1: forward register, delivery counters and idle flag
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      burst_cnt <= '0;
      d_data    <= '0;
      d0_push   <= 1'b0;
      d1_push   <= 1'b0;
      sent0     <= 8'd0;
      sent1     <= 8'd0;
      idle_arb  <= 1'b1;
    end else begin
      burst_cnt <= burst_cnt_nxt;
      d0_push   <= vld_p0 & ~word_p0[DEST_BIT];
      d1_push   <= vld_p0 & word_p0[DEST_BIT];
      if (vld_p0) begin
        d_data <= word_p0;
      end
      if (d0_push) begin
        sent0 <= sent0 + 8'd1;
      end
      if (d1_push) begin
        sent1 <= sent1 + 8'd1;
      end
      idle_arb  <= vc0_empty & vc1_empty & ~vld_p0;
    end
  end

endmodule
